// File: rtl/bus_read_arbiter.sv
// bus_read_arbiter
// Two-requester read arbiter in front of a single AXI4 read master (AR + R).
// Requester 0 is the IFU fetch port; requester 1 is the LSU load port.
// Grants are round-robin, and only one transaction is in flight at a time.
// The winning request is latched at grant.
// Each 64-bit R beat is lane-selected down to 32 bits using the latched addr[2].
// Optional feature macro: ARB_TIMEOUT_EN adds an R-wait watchdog. After
// TIMEOUT_CYCLES it answers the requester with rresp 2'b11 and then drains
// the late beat.

module bus_read_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_arvalid,
    input  logic [ADDR_W-1:0] ifu_araddr,
    output logic              ifu_arready_o,
    output logic              ifu_rvalid_o,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic [1:0]        ifu_rresp_o,
    input  logic              ifu_rready,

    input  logic              lsu_arvalid,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [2:0]        lsu_arsize,
    output logic              lsu_arready_o,
    output logic              lsu_rvalid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic [1:0]        lsu_rresp_o,
    input  logic              lsu_rready,

    output logic [ADDR_W-1:0] io_master_araddr,
    output logic              io_master_arvalid,
    input  logic              io_master_arready,
    output logic [3:0]        io_master_arid,
    output logic [7:0]        io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,
    input  logic              io_master_rvalid,
    output logic              io_master_rready,
    input  logic [63:0]       io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic [3:0]        io_master_rid,
    input  logic              io_master_rlast
);

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif

    // The lane select needs addr[2], and the response lane is 32 bits wide.
    if (ADDR_W < 3 || DATA_W < 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("bus_read_arbiter: needs ADDR_W >= 3, DATA_W >= 32, TIMEOUT_CYCLES >= 2");
    end

    state_t            state;
    logic              last_lsu;
    logic [ADDR_W-1:0] lat_addr;
    logic [2:0]        lat_size;
    logic [3:0]        lat_id;

    logic              grant_ifu;
    logic              grant_lsu;
    logic              sel_lsu;
    logic              req_rready;
    logic [31:0]       lane;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic [1:0]        resp_code;

    // The IDLE arbitration decision is combinational, so the accept pulse
    // lands in the same cycle as the request. last_lsu breaks ties.
    assign grant_ifu = !rst && (state == IDLE) && ifu_arvalid && (!lsu_arvalid || last_lsu);
    assign grant_lsu = !rst && (state == IDLE) && lsu_arvalid && (!ifu_arvalid || !last_lsu);
    assign ifu_arready_o = grant_ifu;
    assign lsu_arready_o = grant_lsu;

    // The AR channel is driven purely from latched fields, so it stays stable
    // while the slave stalls.
    assign io_master_arvalid = (state == ADDR);
    assign io_master_araddr  = lat_addr;
    assign io_master_arid    = lat_id;
    assign io_master_arsize  = lat_size;
    assign io_master_arlen   = 8'd0;
    assign io_master_arburst = 2'b01;

    assign sel_lsu    = lat_id[0];
    assign req_rready = sel_lsu ? lsu_rready : ifu_rready;
    assign lane       = lat_addr[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             timed_out;
    logic             expired;

    // A real beat arriving in the expiry cycle wins over the watchdog.
    // Once expired, the synthetic error response is held until the
    // requester accepts it.
    assign expired    = (state == DATA) && (timed_out || ((count == LIMIT) && !io_master_rvalid));
    assign resp_valid = expired || ((state == DATA) && io_master_rvalid);
    assign resp_data  = expired ? 32'h0 : lane;
    assign resp_code  = expired ? 2'b11 : ((io_master_rid != lat_id) ? 2'b10 : io_master_rresp);
    assign io_master_rready = ((state == DATA) && !expired && req_rready) || (state == DRAIN);
`else
    assign resp_valid = (state == DATA) && io_master_rvalid;
    assign resp_data  = lane;
    assign resp_code  = (io_master_rid != lat_id) ? 2'b10 : io_master_rresp;
    assign io_master_rready = (state == DATA) && req_rready;
`endif

    // Route the response to the granted requester only; the other sees zeros.
    always_comb begin
        ifu_rvalid_o = 1'b0;
        ifu_rdata_o  = '0;
        ifu_rresp_o  = 2'b00;
        lsu_rvalid_o = 1'b0;
        lsu_rdata_o  = '0;
        lsu_rresp_o  = 2'b00;
        if (state == DATA) begin
            if (sel_lsu) begin
                lsu_rvalid_o = resp_valid;
                lsu_rdata_o  = DATA_W'(resp_data);
                lsu_rresp_o  = resp_code;
            end else begin
                ifu_rvalid_o = resp_valid;
                ifu_rdata_o  = DATA_W'(resp_data);
                ifu_rresp_o  = resp_code;
            end
        end
    end

    // Transaction FSM: latch at grant, present AR, then forward R until rlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_lsu <= 1'b1;
            lat_addr <= '0;
            lat_size <= 3'd0;
            lat_id   <= 4'd0;
`ifdef ARB_TIMEOUT_EN
            count     <= '0;
            timed_out <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ifu) begin
                        lat_addr <= ifu_araddr;
                        lat_size <= 3'b010;
                        lat_id   <= 4'd0;
                        last_lsu <= 1'b0;
                        state    <= ADDR;
                    end else if (grant_lsu) begin
                        lat_addr <= lsu_araddr;
                        lat_size <= lsu_arsize;
                        lat_id   <= 4'd1;
                        last_lsu <= 1'b1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (io_master_arready) begin
                        state <= DATA;
`ifdef ARB_TIMEOUT_EN
                        count     <= '0;
                        timed_out <= 1'b0;
`endif
                    end
                end
`ifdef ARB_TIMEOUT_EN
                DATA: begin
                    if (expired) begin
                        timed_out <= 1'b1;
                        if (req_rready) begin
                            state <= DRAIN;
                        end
                    end else begin
                        if (io_master_rvalid && req_rready && io_master_rlast) begin
                            state <= IDLE;
                        end
                        if (count != LIMIT) begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (io_master_rvalid && io_master_rlast) begin
                        state <= IDLE;
                    end
                end
`else
                DATA: begin
                    if (io_master_rvalid && req_rready && io_master_rlast) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
